// File: rtl/bht_update_ctrl.sv
// Update/lookup arbiter for a branch history table: queues resolved-branch updates,
// shares the single array port with fetch lookups, and sweeps the array clear on reset/flush.
module bht_update_ctrl #(
    parameter int s_index    = 3,
    parameter int num_sets   = 2**s_index,
    parameter int fifo_depth = 2
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               flush,
    input  logic               upd_valid,
    input  logic [s_index-1:0] upd_index,
    input  logic               upd_taken,
    output logic               upd_ready,
    input  logic               lookup_req,
    input  logic [s_index-1:0] lookup_index,
    output logic               lookup_gnt,
    output logic [s_index-1:0] hist_read_index,
    output logic [s_index-1:0] hist_write_index,
    output logic               hist_load,
    output logic               hist_reset,
    output logic               hist_datain,
    output logic               busy,
    output logic               flush_done
);

    localparam logic [0:0] ST_CLEAR = 1'b0;
    localparam logic [0:0] ST_RUN   = 1'b1;

    localparam int PW = (fifo_depth > 1) ? $clog2(fifo_depth) : 1;
    localparam logic [PW-1:0]      PTR_LAST   = PW'(fifo_depth - 1);
    localparam logic [2:0]         DEPTH      = 3'(fifo_depth);
    localparam logic [s_index-1:0] SWEEP_LAST = s_index'(num_sets - 1);

    logic [0:0]         state;
    logic [s_index-1:0] sweep;
    logic [s_index-1:0] q_index [fifo_depth];
    logic               q_taken [fifo_depth];
    logic [PW-1:0]      head;
    logic [PW-1:0]      tail;
    logic [2:0]         count;
    logic               prev_lookup;

    logic in_run;
    logic not_empty;
    logic has_room;
    logic push;
    logic grant_upd;
    logic sweep_end;

    function automatic logic [PW-1:0] ptr_next(input logic [PW-1:0] p);
        return (p == PTR_LAST) ? '0 : p + 1'b1;
    endfunction

    // A pending flush suppresses both the push and the head write so nothing queued
    // reaches the array once a clear has been requested.
    always_comb begin
        in_run    = (state == ST_RUN);
        not_empty = (count != 3'd0);
        has_room  = (count < DEPTH);
        push      = in_run && !flush && upd_valid && has_room;
        grant_upd = in_run && !flush && not_empty && (!lookup_req || prev_lookup);
        sweep_end = !in_run && (sweep == SWEEP_LAST) && !flush;
    end

    always_comb begin
        upd_ready        = 1'b0;
        lookup_gnt       = 1'b0;
        hist_read_index  = '0;
        hist_write_index = '0;
        hist_load        = 1'b0;
        hist_reset       = 1'b0;
        hist_datain      = 1'b0;
        busy             = 1'b0;
        flush_done       = 1'b0;
        if (!reset) begin
            if (!in_run) begin
                hist_reset       = 1'b1;
                hist_write_index = sweep;
                hist_read_index  = lookup_index;
                busy             = 1'b1;
                flush_done       = sweep_end;
            end else begin
                upd_ready = has_room;
                busy      = not_empty;
                if (grant_upd) begin
                    hist_load        = 1'b1;
                    hist_read_index  = q_index[head];
                    hist_write_index = q_index[head];
                    hist_datain      = q_taken[head];
                end else begin
                    lookup_gnt       = lookup_req;
                    hist_read_index  = lookup_index;
                    hist_write_index = not_empty ? q_index[head] : '0;
                end
            end
        end
    end

    // Queue storage carries no reset; validity is tracked purely by count.
    always_ff @(posedge clk) begin
        if (push) begin
            q_index[tail] <= upd_index;
            q_taken[tail] <= upd_taken;
        end
    end

    // prev_lookup resets high so the very first contended cycle favours the update.
    always_ff @(posedge clk) begin
        if (reset) begin
            state       <= ST_CLEAR;
            sweep       <= '0;
            head        <= '0;
            tail        <= '0;
            count       <= '0;
            prev_lookup <= 1'b1;
        end else if (in_run) begin
            if (flush) begin
                state <= ST_CLEAR;
                sweep <= '0;
                head  <= '0;
                tail  <= '0;
                count <= '0;
            end else begin
                if (push)
                    tail <= ptr_next(tail);
                if (grant_upd)
                    head <= ptr_next(head);
                count <= count + 3'(push) - 3'(grant_upd);
                if (not_empty && lookup_req)
                    prev_lookup <= !grant_upd;
            end
        end else begin
            if (flush) begin
                sweep <= '0;
            end else if (sweep == SWEEP_LAST) begin
                state <= ST_RUN;
                sweep <= '0;
            end else begin
                sweep <= sweep + 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_bht_update_ctrl.sv
// Directed bench for bht_update_ctrl: reset sweep, update drain, back-pressure,
// update/lookup alternation, flush discard and reset during a sweep.
module tb_bht_update_ctrl;

    logic       clk = 1'b0;
    logic       reset;
    logic       flush;
    logic       updValid;
    logic [2:0] updIndex;
    logic       updTaken;
    logic       updReady;
    logic       lookupReq;
    logic [2:0] lookupIndex;
    logic       lookupGnt;
    logic [2:0] histReadIndex;
    logic [2:0] histWriteIndex;
    logic       histLoad;
    logic       histReset;
    logic       histDatain;
    logic       busy;
    logic       flushDone;

    int checkCount = 0;
    int errorCount = 0;

    always #5 clk = ~clk;

    bht_update_ctrl #(.s_index(3), .num_sets(8), .fifo_depth(2)) dut (
        .clk              (clk),
        .reset            (reset),
        .flush            (flush),
        .upd_valid        (updValid),
        .upd_index        (updIndex),
        .upd_taken        (updTaken),
        .upd_ready        (updReady),
        .lookup_req       (lookupReq),
        .lookup_index     (lookupIndex),
        .lookup_gnt       (lookupGnt),
        .hist_read_index  (histReadIndex),
        .hist_write_index (histWriteIndex),
        .hist_load        (histLoad),
        .hist_reset       (histReset),
        .hist_datain      (histDatain),
        .busy             (busy),
        .flush_done       (flushDone)
    );

    task automatic checkOutput(input string tag, input logic [31:0] actual, input logic [31:0] expected);
        checkCount++;
        if (actual !== expected) begin
            errorCount++;
            $display("[TB] FAIL %s actual=%0d expected=%0d", tag, actual, expected);
        end
    endtask

    // Inputs change on the falling edge; outputs are sampled 1 ns later, well before the rising edge.
    task automatic applyStimulus(input logic fl, input logic uv, input logic [2:0] ui, input logic ut,
                                 input logic lr, input logic [2:0] li);
        flush       = fl;
        updValid    = uv;
        updIndex    = ui;
        updTaken    = ut;
        lookupReq   = lr;
        lookupIndex = li;
        #1;
    endtask

    task automatic nextCycle();
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic checkRun(input string tag, input logic load, input logic [2:0] rd, input logic [2:0] wr,
                            input logic din, input logic gnt, input logic rdy);
        checkOutput({tag, ".load"},  32'(histLoad),       32'(load));
        checkOutput({tag, ".read"},  32'(histReadIndex),  32'(rd));
        checkOutput({tag, ".write"}, 32'(histWriteIndex), 32'(wr));
        checkOutput({tag, ".din"},   32'(histDatain),     32'(din));
        checkOutput({tag, ".gnt"},   32'(lookupGnt),      32'(gnt));
        checkOutput({tag, ".ready"}, 32'(updReady),       32'(rdy));
    endtask

    task automatic checkSweepCycle(input string tag, input int idx);
        checkOutput({tag, ".hreset"}, 32'(histReset),      32'd1);
        checkOutput({tag, ".widx"},   32'(histWriteIndex), 32'(idx));
        checkOutput({tag, ".load"},   32'(histLoad),       32'd0);
        checkOutput({tag, ".ready"},  32'(updReady),       32'd0);
        checkOutput({tag, ".gnt"},    32'(lookupGnt),      32'd0);
        checkOutput({tag, ".fdone"},  32'(flushDone),      32'(idx == 7));
    endtask

    task automatic fullSweep(input string tag);
        for (int i = 0; i < 8; i++) begin
            applyStimulus(1'b0, 1'b0, 3'd0, 1'b0, 1'b1, 3'd2);
            checkSweepCycle(tag, i);
            nextCycle();
        end
    endtask

    task automatic checkAllZero(input string tag);
        checkOutput({tag, ".hreset"}, 32'(histReset),  32'd0);
        checkOutput({tag, ".load"},   32'(histLoad),   32'd0);
        checkOutput({tag, ".ready"},  32'(updReady),   32'd0);
        checkOutput({tag, ".gnt"},    32'(lookupGnt),  32'd0);
        checkOutput({tag, ".busy"},   32'(busy),       32'd0);
        checkOutput({tag, ".fdone"},  32'(flushDone),  32'd0);
        checkOutput({tag, ".ridx"},   32'(histReadIndex), 32'd0);
    endtask

    initial begin
        reset = 1'b1;
        applyStimulus(1'b0, 1'b1, 3'd5, 1'b1, 1'b1, 3'd6);
        repeat (2) @(negedge clk);
        #1;
        checkAllZero("reset");
        nextCycle();
        reset = 1'b0;

        fullSweep("sweep0");
        applyStimulus(1'b0, 1'b0, 3'd0, 1'b0, 1'b0, 3'd0);
        checkOutput("run.ready", 32'(updReady),  32'd1);
        checkOutput("run.hreset", 32'(histReset), 32'd0);
        checkOutput("run.busy",  32'(busy),      32'd0);

        // Two back-to-back updates to index 5, no lookups.
        applyStimulus(1'b0, 1'b1, 3'd5, 1'b1, 1'b0, 3'd0);
        checkRun("drainA", 1'b0, 3'd0, 3'd0, 1'b0, 1'b0, 1'b1);
        nextCycle();
        applyStimulus(1'b0, 1'b1, 3'd5, 1'b0, 1'b0, 3'd0);
        checkRun("drainB", 1'b1, 3'd5, 3'd5, 1'b1, 1'b0, 1'b1);
        checkOutput("drainB.busy", 32'(busy), 32'd1);
        nextCycle();
        applyStimulus(1'b0, 1'b0, 3'd0, 1'b0, 1'b0, 3'd0);
        checkRun("drainC", 1'b1, 3'd5, 3'd5, 1'b0, 1'b0, 1'b1);
        nextCycle();
        applyStimulus(1'b0, 1'b0, 3'd0, 1'b0, 1'b0, 3'd0);
        checkRun("drainD", 1'b0, 3'd0, 3'd0, 1'b0, 1'b0, 1'b1);
        checkOutput("drainD.busy", 32'(busy), 32'd0);
        nextCycle();

        // Lookup held on index 3 while updates 1,2,3,4 stream in; queue fills and back-pressures.
        applyStimulus(1'b0, 1'b1, 3'd1, 1'b1, 1'b1, 3'd3);
        checkRun("arb1", 1'b0, 3'd3, 3'd0, 1'b0, 1'b1, 1'b1);
        nextCycle();
        applyStimulus(1'b0, 1'b1, 3'd2, 1'b0, 1'b1, 3'd3);
        checkRun("arb2", 1'b1, 3'd1, 3'd1, 1'b1, 1'b0, 1'b1);
        nextCycle();
        applyStimulus(1'b0, 1'b1, 3'd3, 1'b1, 1'b1, 3'd3);
        checkRun("arb3", 1'b0, 3'd3, 3'd2, 1'b0, 1'b1, 1'b1);
        nextCycle();
        applyStimulus(1'b0, 1'b1, 3'd4, 1'b0, 1'b1, 3'd3);
        checkRun("arb4", 1'b1, 3'd2, 3'd2, 1'b0, 1'b0, 1'b0);
        nextCycle();
        applyStimulus(1'b0, 1'b1, 3'd4, 1'b0, 1'b1, 3'd3);
        checkRun("arb5", 1'b0, 3'd3, 3'd3, 1'b0, 1'b1, 1'b1);
        nextCycle();
        applyStimulus(1'b0, 1'b0, 3'd0, 1'b0, 1'b1, 3'd3);
        checkRun("arb6", 1'b1, 3'd3, 3'd3, 1'b1, 1'b0, 1'b0);
        nextCycle();
        applyStimulus(1'b0, 1'b0, 3'd0, 1'b0, 1'b1, 3'd3);
        checkRun("arb7", 1'b0, 3'd3, 3'd4, 1'b0, 1'b1, 1'b1);
        nextCycle();
        applyStimulus(1'b0, 1'b0, 3'd0, 1'b0, 1'b1, 3'd3);
        checkRun("arb8", 1'b1, 3'd4, 3'd4, 1'b0, 1'b0, 1'b1);
        nextCycle();
        applyStimulus(1'b0, 1'b0, 3'd0, 1'b0, 1'b0, 3'd0);
        checkOutput("arb9.busy", 32'(busy), 32'd0);
        checkOutput("arb9.gnt",  32'(lookupGnt), 32'd0);
        nextCycle();

        // Queue two updates, then flush: neither may reach the array.
        applyStimulus(1'b0, 1'b1, 3'd5, 1'b1, 1'b1, 3'd0);
        checkRun("fl1", 1'b0, 3'd0, 3'd0, 1'b0, 1'b1, 1'b1);
        nextCycle();
        applyStimulus(1'b0, 1'b1, 3'd6, 1'b1, 1'b1, 3'd0);
        checkRun("fl2", 1'b0, 3'd0, 3'd5, 1'b0, 1'b1, 1'b1);
        nextCycle();
        applyStimulus(1'b1, 1'b1, 3'd7, 1'b1, 1'b0, 3'd0);
        checkOutput("fl3.load", 32'(histLoad), 32'd0);
        checkOutput("fl3.busy", 32'(busy),     32'd1);
        nextCycle();
        fullSweep("sweep1");
        applyStimulus(1'b0, 1'b0, 3'd0, 1'b0, 1'b0, 3'd0);
        checkOutput("postfl.load",  32'(histLoad), 32'd0);
        checkOutput("postfl.busy",  32'(busy),     32'd0);
        checkOutput("postfl.ready", 32'(updReady), 32'd1);
        nextCycle();
        applyStimulus(1'b0, 1'b0, 3'd0, 1'b0, 1'b0, 3'd0);
        checkOutput("postfl2.load", 32'(histLoad), 32'd0);

        // Flush again, abort the sweep with reset at index 4, then expect a complete sweep.
        applyStimulus(1'b1, 1'b0, 3'd0, 1'b0, 1'b0, 3'd0);
        nextCycle();
        for (int i = 0; i < 4; i++) begin
            applyStimulus(1'b0, 1'b0, 3'd0, 1'b0, 1'b1, 3'd2);
            checkSweepCycle("sweep2", i);
            nextCycle();
        end
        reset = 1'b1;
        applyStimulus(1'b0, 1'b0, 3'd0, 1'b0, 1'b1, 3'd2);
        checkAllZero("midreset");
        nextCycle();
        reset = 1'b0;
        fullSweep("sweep3");
        applyStimulus(1'b0, 1'b0, 3'd0, 1'b0, 1'b0, 3'd0);
        checkOutput("final.ready", 32'(updReady), 32'd1);

        $display("CHECKS %0d ERRORS %0d", checkCount, errorCount);
        $finish;
    end

endmodule
